// File: rtl/lamp_pkg.sv
// Shared definitions for the lamp shell channels: state encoding, default
// PWM timing and the duty word width.
package lamp_pkg;

    localparam int DUTY_W     = 16;
    localparam int PERIOD_DEF = 50_000;
    localparam int STEP_DEF   = 500;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RISE = 2'd1,
        HOLD = 2'd2,
        FALL = 2'd3
    } lamp_state_t;

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] duty,
                                                     input logic [DUTY_W-1:0] limit);
        return (duty > limit) ? limit : duty;
    endfunction

endpackage

// File: rtl/lamp_fade_pwm_if.sv
// Request/status bundle between a lamp controller and one fade PWM channel.
interface lamp_fade_pwm_if;
    import lamp_pkg::*;

    logic              en;
    logic [DUTY_W-1:0] duty_max;
    logic              pwm;
    logic [DUTY_W-1:0] level;
    lamp_state_t       state;
    logic              done;

    modport master (output en, output duty_max,
                    input pwm, input level, input state, input done);
    modport slave  (input en, input duty_max,
                    output pwm, output level, output state, output done);

endinterface

// File: rtl/pwm_period_cnt.sv
// Wrapping PWM period counter with a strobe on the last cycle of each period.
module pwm_period_cnt
    import lamp_pkg::*;
#(
    parameter int PERIOD = PERIOD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DUTY_W-1:0] cnt,
    output logic              boundary
);

    localparam logic [DUTY_W-1:0] LAST = DUTY_W'(PERIOD - 1);

    assign boundary = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (boundary) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DUTY_W'(1);
        end
    end

endmodule

// File: rtl/lamp_fade_pwm.sv
// Soft-fade PWM channel: level ramps by STEP once per period toward the
// requested target, so duty only ever changes on a period boundary.
module lamp_fade_pwm
    import lamp_pkg::*;
#(
    parameter int PERIOD = PERIOD_DEF,
    parameter int STEP   = STEP_DEF
) (
    input  logic            clk,
    input  logic            rst,
    lamp_fade_pwm_if.slave  bus
);

    localparam logic [DUTY_W-1:0] PERIOD_V = DUTY_W'(PERIOD);
    localparam logic [DUTY_W-1:0] STEP_V   = DUTY_W'(STEP);

    logic [DUTY_W-1:0] cnt;
    logic              boundary;
    logic [DUTY_W-1:0] tgt;
    logic [DUTY_W:0]   rise_sum;
    logic [DUTY_W-1:0] level, level_nxt;
    lamp_state_t       state, state_nxt;
    logic              done, done_nxt;
    logic              pwm;

    pwm_period_cnt #(.PERIOD(PERIOD)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .cnt      (cnt),
        .boundary (boundary)
    );

    assign tgt      = bus.en ? clamp_duty(bus.duty_max, PERIOD_V) : '0;
    assign rise_sum = {1'b0, level} + {1'b0, STEP_V};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OFF;
        end else begin
            state <= state_nxt;
        end
    end

    // Inputs are only looked at on the boundary cycle; state follows the new level.
    always_comb begin
        level_nxt = level;
        state_nxt = state;
        done_nxt  = 1'b0;
        if (boundary) begin
            if (level < tgt) begin
                level_nxt = (rise_sum > {1'b0, tgt}) ? tgt : rise_sum[DUTY_W-1:0];
            end else if (level > tgt) begin
                level_nxt = ((level - tgt) > STEP_V) ? (level - STEP_V) : tgt;
            end
            if (level_nxt == tgt) begin
                state_nxt = (tgt == '0) ? OFF : HOLD;
            end else if (level_nxt < tgt) begin
                state_nxt = RISE;
            end else begin
                state_nxt = FALL;
            end
            done_nxt = (level_nxt != level) && (level_nxt == tgt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
            done  <= 1'b0;
            pwm   <= 1'b0;
        end else begin
            level <= level_nxt;
            done  <= done_nxt;
            pwm   <= (cnt < level);
        end
    end

    assign bus.level = level;
    assign bus.state = state;
    assign bus.done  = done;
    assign bus.pwm   = pwm;

endmodule

// File: tb/tb_lamp_fade_pwm.sv
// Self-checking bench: directed fade scenarios plus random requests, all
// compared every cycle against a period-level behavioural model.
module tb_lamp_fade_pwm;
    import lamp_pkg::*;

    localparam int P = 100;
    localparam int S = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lamp_fade_pwm_if bus ();

    lamp_fade_pwm #(.PERIOD(P), .STEP(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    int m_pos   = 0;
    int m_level = 0;
    int m_state = 0;
    int m_pwm   = 0;
    int m_done  = 0;
    int m_tgt;
    int m_new;

    // Reference: position within the period, and one level decision per period.
    always @(posedge clk) begin
        if (rst) begin
            m_pos = 0; m_level = 0; m_state = 0; m_pwm = 0; m_done = 0;
        end else begin
            m_pwm  = (m_pos < m_level) ? 1 : 0;
            m_done = 0;
            if (m_pos == P - 1) begin
                m_tgt = bus.en ? ((int'(bus.duty_max) > P) ? P : int'(bus.duty_max)) : 0;
                if (m_level < m_tgt)
                    m_new = (m_level + S < m_tgt) ? m_level + S : m_tgt;
                else if (m_level > m_tgt)
                    m_new = (m_level - S > m_tgt) ? m_level - S : m_tgt;
                else
                    m_new = m_level;
                if (m_new == m_tgt) m_state = (m_tgt == 0) ? 0 : 2;
                else                m_state = (m_new < m_tgt) ? 1 : 3;
                m_done  = (m_new != m_level && m_new == m_tgt) ? 1 : 0;
                m_level = m_new;
                m_pos   = 0;
            end else begin
                m_pos = m_pos + 1;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check_output("model_level", 32'(bus.level), 32'(m_level));
            check_output("model_state", 32'(bus.state), 32'(m_state));
            check_output("model_pwm",   32'(bus.pwm),   32'(m_pwm));
            check_output("model_done",  32'(bus.done),  32'(m_done));
        end
    end

    task automatic apply_stimulus(input logic e, input logic [15:0] d);
        bus.en       = e;
        bus.duty_max = d;
    endtask

    task automatic next_boundary();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_pos != 0 && n < 3 * P);
        if (m_pos != 0) begin
            bad++;
            $display("[TB] FAIL boundary_wait: no period wrap within %0d cycles", 3 * P);
        end
    endtask

    task automatic count_pwm(output int c);
        c = 0;
        repeat (P) begin
            @(negedge clk);
            if (bus.pwm === 1'b1) c++;
        end
    endtask

    task automatic walk(input int n);
        repeat (n) next_boundary();
    endtask

    int hi;
    int dsel;

    initial begin
        apply_stimulus(1'b0, 16'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_on = 1'b1;
        check_output("reset_level", 32'(bus.level), 32'd0);
        check_output("reset_state", 32'(bus.state), 32'(OFF));
        check_output("reset_pwm",   32'(bus.pwm),   32'd0);
        check_output("reset_done",  32'(bus.done),  32'd0);
        check_output("reset_cnt",   32'(dut.cnt),   32'd0);

        $display("[TB] rise to 50");
        apply_stimulus(1'b1, 16'd50);
        for (int k = 1; k <= 5; k++) begin
            next_boundary();
            check_output("rise50_level", 32'(bus.level), 32'(10 * k));
            check_output("rise50_state", 32'(bus.state), (k < 5) ? 32'(RISE) : 32'(HOLD));
            check_output("rise50_done",  32'(bus.done),  (k == 5) ? 32'd1 : 32'd0);
        end
        count_pwm(hi);
        check_output("hold50_pwm_high", 32'(hi), 32'd50);

        $display("[TB] fall to 0");
        apply_stimulus(1'b0, 16'd50);
        for (int k = 1; k <= 5; k++) begin
            next_boundary();
            check_output("fall_level", 32'(bus.level), 32'(50 - 10 * k));
            check_output("fall_state", 32'(bus.state), (k < 5) ? 32'(FALL) : 32'(OFF));
        end
        count_pwm(hi);
        check_output("off_pwm_high", 32'(hi), 32'd0);

        $display("[TB] clamp 200 to period");
        apply_stimulus(1'b1, 16'd200);
        walk(10);
        check_output("clamp_level", 32'(bus.level), 32'd100);
        check_output("clamp_state", 32'(bus.state), 32'(HOLD));
        count_pwm(hi);
        check_output("full_pwm_high", 32'(hi), 32'd100);
        apply_stimulus(1'b0, 16'd0);
        walk(10);
        check_output("clamp_back_level", 32'(bus.level), 32'd0);

        $display("[TB] reversal at 30");
        apply_stimulus(1'b1, 16'd60);
        walk(3);
        check_output("rev_peak_level", 32'(bus.level), 32'd30);
        apply_stimulus(1'b0, 16'd60);
        for (int k = 1; k <= 3; k++) begin
            next_boundary();
            check_output("rev_level", 32'(bus.level), 32'(30 - 10 * k));
            check_output("rev_state", 32'(bus.state), (k < 3) ? 32'(FALL) : 32'(OFF));
        end

        $display("[TB] non-multiple target 25");
        apply_stimulus(1'b1, 16'd25);
        for (int k = 1; k <= 3; k++) begin
            next_boundary();
            check_output("t25_level", 32'(bus.level), (k < 3) ? 32'(10 * k) : 32'd25);
            check_output("t25_state", 32'(bus.state), (k < 3) ? 32'(RISE) : 32'(HOLD));
            check_output("t25_done",  32'(bus.done),  (k == 3) ? 32'd1 : 32'd0);
        end
        next_boundary();
        check_output("t25_hold_level", 32'(bus.level), 32'd25);
        check_output("t25_no_repulse", 32'(bus.done),  32'd0);
        apply_stimulus(1'b0, 16'd0);
        walk(3);

        $display("[TB] reset mid-rise");
        apply_stimulus(1'b1, 16'd60);
        walk(4);
        check_output("rst_pre_level", 32'(bus.level), 32'd40);
        repeat (37) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("rst_mid_level", 32'(bus.level), 32'd0);
        check_output("rst_mid_pwm",   32'(bus.pwm),   32'd0);
        check_output("rst_mid_state", 32'(bus.state), 32'(OFF));
        check_output("rst_mid_cnt",   32'(dut.cnt),   32'd0);
        rst = 1'b0;
        next_boundary();
        check_output("rst_restart_level", 32'(bus.level), 32'd10);
        check_output("rst_restart_state", 32'(bus.state), 32'(RISE));

        $display("[TB] random requests");
        repeat (60) begin
            dsel = int'($urandom_range(0, 9));
            case (dsel)
                0:       apply_stimulus(1'b1, 16'd0);
                1:       apply_stimulus(1'b1, 16'd100);
                2:       apply_stimulus(1'b1, 16'd101);
                3:       apply_stimulus(1'b1, 16'hFFFF);
                default: apply_stimulus($urandom_range(0, 3) != 0, 16'($urandom_range(0, 130)));
            endcase
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            repeat ($urandom_range(1, 150)) @(negedge clk);
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
